// File: rtl/tetris_pkg.sv
// Shared Tetris board geometry, piece codes, colour palette and
// board-scan FSM states.
package tetris_pkg;

    localparam int BOARD_COLS   = 10;
    localparam int BOARD_ROWS   = 20;
    localparam int BOARD_CELL_W = 64;
    localparam int BOARD_CELL_H = 24;
    localparam int PIECE_CODE_W = 3;

    typedef enum logic [PIECE_CODE_W-1:0] {
        EMPTY   = 3'd0,
        PIECE_I = 3'd1,
        PIECE_O = 3'd2,
        PIECE_T = 3'd3,
        PIECE_S = 3'd4,
        PIECE_Z = 3'd5,
        PIECE_J = 3'd6,
        PIECE_L = 3'd7
    } piece_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_DRAW,
        ST_FIN
    } scan_state_e;

    // Colours are RRR_GGG_BBB.
    function automatic logic [8:0] palette(input piece_e code);
        case (code)
            EMPTY:   palette = 9'b000_000_000;
            PIECE_I: palette = 9'b000_111_111;
            PIECE_O: palette = 9'b111_111_000;
            PIECE_T: palette = 9'b101_000_111;
            PIECE_S: palette = 9'b000_111_000;
            PIECE_Z: palette = 9'b111_000_000;
            PIECE_J: palette = 9'b000_000_111;
            PIECE_L: palette = 9'b111_100_000;
            default: palette = 9'b000_000_000;
        endcase
    endfunction

endpackage

// File: rtl/cell_palette.sv
// Combinational piece-code to 9-bit colour lookup, shared by the board
// scanner and the next-piece preview.
module cell_palette
    import tetris_pkg::*;
#(
    parameter int CODE_W = PIECE_CODE_W
) (
    input  logic [CODE_W-1:0] i_code,
    output logic [8:0]        o_color
);

    assign o_color = palette(piece_e'(i_code));

endmodule

// File: rtl/board_scan_render.sv
// Walks the board row by row, reads each cell code, and issues one
// box-draw command per cell, waiting for the drawer's done pulse.
module board_scan_render
    import tetris_pkg::*;
#(
    parameter int COLS   = BOARD_COLS,
    parameter int ROWS   = BOARD_ROWS,
    parameter int CELL_W = BOARD_CELL_W,
    parameter int CELL_H = BOARD_CELL_H,
    parameter int CODE_W = PIECE_CODE_W,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              frame_req,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [CODE_W-1:0] cell_code,
    output logic              box_start,
    output logic [9:0]        box_x0,
    output logic [8:0]        box_y0,
    output logic [8:0]        box_color,
    input  logic              box_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    scan_state_e       r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_pending;
    logic [ADDR_W-1:0] r_cell_addr;
    logic              r_box_start;
    logic [9:0]        r_box_x0;
    logic [8:0]        r_box_y0;
    logic [8:0]        r_box_color;
    logic              r_busy;
    logic              r_frame_done;

    logic [8:0]        w_color;
    logic              w_last_col;
    logic              w_last_cell;

    cell_palette #(
        .CODE_W (CODE_W)
    ) u_palette (
        .i_code  (cell_code),
        .o_color (w_color)
    );

    assign w_last_col  = (r_col == COL_W'(COLS - 1));
    assign w_last_cell = w_last_col && (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_pending    <= 1'b0;
            r_cell_addr  <= '0;
            r_box_start  <= 1'b0;
            r_box_x0     <= '0;
            r_box_y0     <= '0;
            r_box_color  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_box_start  <= 1'b0;
            r_frame_done <= 1'b0;

            // Requests arriving while a frame is in flight coalesce into one.
            if (frame_req && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (frame_req || r_pending) begin
                        r_pending <= 1'b0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_cell_addr <= ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_box_color <= w_color;
                    r_box_x0    <= 10'(r_col) * 10'(CELL_W);
                    r_box_y0    <= 9'(r_row) * 9'(CELL_H);
                    r_state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_box_start <= 1'b1;
                    r_state     <= ST_DRAW;
                end
                ST_DRAW: begin
                    // Box coordinates/colour are only written in WAIT, so they
                    // hold for the drawer however long it takes.
                    if (box_done) begin
                        if (w_last_cell) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= ST_FIN;
                        end else begin
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FIN: begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cell_addr  = r_cell_addr;
    assign box_start  = r_box_start;
    assign box_x0     = r_box_x0;
    assign box_y0     = r_box_y0;
    assign box_color  = r_box_color;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_board_scan_render.sv
// Scoreboard bench for board_scan_render: random board contents, a random
// latency box drawer, and an expected-command queue built from board geometry.
module tb_board_scan_render;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int NCELLS = COLS * ROWS;

    logic       CLOCK_50;
    logic       resetn;
    logic       frame_req;
    logic [7:0] cell_addr;
    logic [2:0] cell_code;
    logic       box_start;
    logic [9:0] box_x0;
    logic [8:0] box_y0;
    logic [8:0] box_color;
    logic       box_done;
    logic       busy;
    logic       frame_done;

    typedef struct {
        int unsigned addr;
        int unsigned x0;
        int unsigned y0;
        int unsigned color;
    } cell_t;

    cell_t       exp_q[$];
    int unsigned mem[256];
    int unsigned pal[8];

    int checks       = 0;
    int errors       = 0;
    int frames_seen  = 0;
    int frame_cells  = 0;
    int total_starts = 0;
    int stall_next   = 0;

    board_scan_render dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .frame_req  (frame_req),
        .cell_addr  (cell_addr),
        .cell_code  (cell_code),
        .box_start  (box_start),
        .box_x0     (box_x0),
        .box_y0     (box_y0),
        .box_color  (box_color),
        .box_done   (box_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Board storage: data for the presented address is ready by the next rising edge.
    always @(negedge CLOCK_50) cell_code = 3'(mem[cell_addr]);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        cell_t c;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                c.addr  = r * COLS + k;
                c.x0    = k * 64;
                c.y0    = r * 24;
                c.color = pal[mem[c.addr]];
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic randomize_board();
        for (int i = 0; i < 256; i++) mem[i] = $urandom_range(7, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cell_addr",  int'(cell_addr),  0);
        chk("rst_box_start",  int'(box_start),  0);
        chk("rst_box_x0",     int'(box_x0),     0);
        chk("rst_box_y0",     int'(box_y0),     0);
        chk("rst_box_color",  int'(box_color),  0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_frame_done", int'(frame_done), 0);
    endtask

    task automatic monitor();
        cell_t c;
        forever begin
            @(negedge CLOCK_50);
            if (resetn) begin
                if (box_start) begin
                    total_starts++;
                    frame_cells++;
                    chk("busy_during_box", int'(busy), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_box_start: got box_start at cell_addr %0d, expected none (t=%0t)",
                                 cell_addr, $time);
                    end else begin
                        c = exp_q.pop_front();
                        chk("cell_addr", int'(cell_addr), int'(c.addr));
                        chk("box_x0",    int'(box_x0),    int'(c.x0));
                        chk("box_y0",    int'(box_y0),    int'(c.y0));
                        chk("box_color", int'(box_color), int'(c.color));
                    end
                end
                if (frame_done) begin
                    chk("cells_per_frame", frame_cells, NCELLS);
                    frame_cells = 0;
                    frames_seen++;
                end
            end
        end
    endtask

    task automatic drawer();
        int d;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (resetn && box_start) begin
                d = (stall_next > 0) ? stall_next : int'($urandom_range(4, 1));
                stall_next = 0;
                for (int i = 0; i < d && resetn; i++) @(posedge CLOCK_50);
                #1;
                if (resetn) begin
                    box_done = 1'b1;
                    @(posedge CLOCK_50);
                    #1;
                    box_done = 1'b0;
                end
            end
        end
    endtask

    task automatic start_frame(input bit check_latency);
        int n;
        push_frame();
        @(negedge CLOCK_50);
        frame_req = 1'b1;
        @(posedge CLOCK_50);
        #1;
        frame_req = 1'b0;
        chk("busy_on_accept", int'(busy), 1);
        n = 1;
        while (!box_start && n < 20) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        if (check_latency) chk("first_start_latency", n, 4);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_seen < target && n < 8000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("frame_count", frames_seen, target);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_addr(input int target);
        int n = 0;
        while (int'(cell_addr) != target && n < 4000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("reach_cell_addr", int'(cell_addr), target);
    endtask

    initial begin
        int base_f;
        int base_s;
        int n;
        int bad;
        int hold_x0;
        int hold_y0;
        int hold_col;
        int hold_addr;

        pal = '{9'b000_000_000, 9'b000_111_111, 9'b111_111_000, 9'b101_000_111,
                9'b000_111_000, 9'b111_000_000, 9'b000_000_111, 9'b111_100_000};
        resetn    = 1'b1;
        frame_req = 1'b0;
        box_done  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 0;

        fork
            monitor();
            drawer();
        join_none

        #5 resetn = 1'b0;
        #20;
        chk_reset_outputs();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // All-empty board, latency of first command, last-cell geometry.
        base_f = frames_seen;
        start_frame(1'b1);
        wait_frames(base_f + 1);
        repeat (3) @(negedge CLOCK_50);
        chk("last_cell_addr", int'(cell_addr), 199);
        chk("last_box_x0",    int'(box_x0),    576);
        chk("last_box_y0",    int'(box_y0),    456);
        chk("idle_busy",      int'(busy),      0);

        // Random board with a T piece at cell 37, and a long drawer stall at cell 12.
        randomize_board();
        mem[37] = 3;
        base_f = frames_seen;
        start_frame(1'b0);
        wait_addr(12);
        stall_next = 500;
        n = 0;
        while (!box_start && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("stall_start_seen", int'(box_start), 1);
        hold_x0   = int'(box_x0);
        hold_y0   = int'(box_y0);
        hold_col  = int'(box_color);
        hold_addr = int'(cell_addr);
        bad = 0;
        repeat (499) begin
            @(negedge CLOCK_50);
            if (box_start || !busy || int'(box_x0) != hold_x0 || int'(box_y0) != hold_y0 ||
                int'(box_color) != hold_col || int'(cell_addr) != hold_addr)
                bad++;
        end
        chk("stall_hold", bad, 0);
        wait_frames(base_f + 1);

        // Three requests during a frame coalesce into exactly one extra frame.
        randomize_board();
        base_f = frames_seen;
        base_s = total_starts;
        start_frame(1'b0);
        push_frame();
        foreach (pal[i]) begin
            if (i < 3) begin
                wait_addr(30 + 60 * i);
                frame_req = 1'b1;
                @(negedge CLOCK_50);
                frame_req = 1'b0;
            end
        end
        wait_frames(base_f + 2);
        repeat (60) @(negedge CLOCK_50);
        chk("extra_frame_starts", total_starts - base_s, 2 * NCELLS);
        chk("busy_after_extra", int'(busy), 0);

        // Reset in the middle of a frame, then a clean restart.
        randomize_board();
        start_frame(1'b0);
        wait_addr(57);
        resetn = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        frame_cells = 0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (i == 5) box_done = 1'b1;
            if (i == 6) box_done = 1'b0;
            if (box_start || busy || frame_done || cell_addr != 8'd0) bad++;
        end
        chk("idle_after_reset", bad, 0);
        base_f = frames_seen;
        start_frame(1'b1);
        wait_frames(base_f + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
